// File: rtl/c24_pkg.sv
// Shared types and constants for the two-digit BCD 24-second shot clock.
// The down-count helper is used by both digit cells.
package c24_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MOD_TENS       = 4'd2;
    localparam bcd_t MOD_UNITS_WRAP = 4'd3;
    localparam bcd_t BCD_MAX        = 4'd9;

    // A digit at zero reloads its wrap value; any other value steps down in binary.
    function automatic bcd_t count_down(input bcd_t q, input bcd_t wrap);
        return (q == 4'd0) ? wrap : q - 4'd1;
    endfunction

endpackage

// File: rtl/c24_digit.sv
// One 74x161-style down-counting digit cell: async clear, sync load, count, hold.
// The wrap value is supplied from outside so that the same cell serves both digits.
module c24_digit
    import c24_pkg::*;
(
    input  logic CP,
    input  logic CR,
    input  logic PE,
    input  logic CEP,
    input  logic CET,
    input  bcd_t D,
    input  bcd_t WRAP,
    output bcd_t Q,
    output logic TC
);

    bcd_t q_next;

    // Priority order: clear, then load, then count, otherwise hold.
    always_comb begin
        q_next = Q;
        if (!PE) begin
            q_next = D;
        end else if (CEP && CET) begin
            q_next = count_down(Q, WRAP);
        end
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    assign TC = CET && (Q == 4'd0);

endmodule

// File: rtl/c24_counter.sv
// Two-digit BCD modulo-24 down counter for the shot clock.
// Chains the units borrow into the tens enable and selects the units wrap value.
module c24_counter
    import c24_pkg::*;
(
    input  logic       CP,
    input  logic       CR0,
    input  logic       CR1,
    input  logic       PE0,
    input  logic       PE1,
    input  logic       CEP0,
    input  logic       CET0,
    input  logic       CEP1,
    input  logic       CET1,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    output logic [3:0] Q0,
    output logic [3:0] Q1,
    output logic       TC0,
    output logic       TC1
);

    bcd_t units_wrap;
    logic tens_cet;

    // Units wraps 0 -> 3 only when tens is already 0, so that 00 is followed by 23.
    assign units_wrap = (Q1 == 4'd0) ? MOD_UNITS_WRAP : BCD_MAX;

    // Tens steps only when the units digit borrows; this also makes TC1 the expiry flag.
    assign tens_cet = CET1 && TC0;

    c24_digit u_units (
        .CP   (CP),
        .CR   (CR0),
        .PE   (PE0),
        .CEP  (CEP0),
        .CET  (CET0),
        .D    (D0),
        .WRAP (units_wrap),
        .Q    (Q0),
        .TC   (TC0)
    );

    c24_digit u_tens (
        .CP   (CP),
        .CR   (CR1),
        .PE   (PE1),
        .CEP  (CEP1),
        .CET  (tens_cet),
        .D    (D1),
        .WRAP (MOD_TENS),
        .Q    (Q1),
        .TC   (TC1)
    );

endmodule

// File: tb/tb_c24_counter.sv
// Self-checking bench for the shot-clock counter: expected digits and TC flags
// are queued when stimulus is applied and compared after the following edge.
module tb_c24_counter;

    logic       CP = 1'b0;
    logic       CR0, CR1, PE0, PE1, CEP0, CET0, CEP1, CET1;
    logic [3:0] D0, D1;
    logic [3:0] Q0, Q1;
    logic       TC0, TC1;

    typedef struct packed {
        logic [3:0] q1;
        logic [3:0] q0;
        logic       tc0;
        logic       tc1;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    c24_counter dut (
        .CP   (CP),
        .CR0  (CR0),
        .CR1  (CR1),
        .PE0  (PE0),
        .PE1  (PE1),
        .CEP0 (CEP0),
        .CET0 (CET0),
        .CEP1 (CEP1),
        .CET1 (CET1),
        .D0   (D0),
        .D1   (D1),
        .Q0   (Q0),
        .Q1   (Q1),
        .TC0  (TC0),
        .TC1  (TC1)
    );

    // Rising edges at 50, 150, 250 ns ...
    always #50 CP = ~CP;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge: drive inputs, queue the expectation, then
    // compare on the next falling edge, once the rising edge has acted.
    task automatic applyStimulus(input string tag,
                                 input logic pe0, input logic pe1,
                                 input logic cep0, input logic cet0,
                                 input logic cep1, input logic cet1,
                                 input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [3:0] e1, input logic [3:0] e0);
        exp_t e;
        PE0 = pe0; PE1 = pe1; CEP0 = cep0; CET0 = cet0;
        CEP1 = cep1; CET1 = cet1; D0 = d0; D1 = d1;
        e.q1  = e1;
        e.q0  = e0;
        e.tc0 = cet0 && (e0 == 4'd0);
        e.tc1 = cet1 && e.tc0 && (e1 == 4'd0);
        sbq.push_back(e);
        @(posedge CP);
        @(negedge CP);
        e = sbq.pop_front();
        checkOutput(tag, {Q1, Q0}, {e.q1, e.q0});
        checkOutput({tag, "_tc"}, {6'd0, TC0, TC1}, {6'd0, e.tc0, e.tc1});
    endtask

    // Plain counting step, expected value from modulo-24 decimal arithmetic.
    task automatic countStep(input string tag);
        cur = (cur + 23) % 24;
        applyStimulus(tag, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd2,
                      4'(cur / 10), 4'(cur % 10));
    endtask

    // 20 ns clear pulse between edges; the digits must already read 00 mid-pulse.
    task automatic clearPulse(input string tag);
        CR0 = 1'b0; CR1 = 1'b0;
        #10;
        checkOutput(tag, {Q1, Q0}, 8'h00);
        #10;
        CR0 = 1'b1; CR1 = 1'b1;
        cur = 0;
    endtask

    initial begin
        CR0 = 1'b0; CR1 = 1'b0;
        PE0 = 1'b1; PE1 = 1'b1;
        CEP0 = 1'b0; CET0 = 1'b1; CEP1 = 1'b0; CET1 = 1'b1;
        D0 = 4'd4; D1 = 4'd2;
        #10;
        checkOutput("reset_q", {Q1, Q0}, 8'h00);
        checkOutput("reset_tc", {6'd0, TC0, TC1}, 8'h03);
        #10;
        CR0 = 1'b1; CR1 = 1'b1;
        @(negedge CP);
        checkOutput("idle_hold", {Q1, Q0}, 8'h00);

        applyStimulus("preset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd2, 4'd2, 4'd4);
        cur = 24;
        for (int i = 0; i < 6; i++) countStep("count_down");

        // Run through 01 and 00 (TC flags checked at 00), then wrap to 23 and 22.
        while (cur != 0) countStep("to_zero");
        countStep("wrap_23");
        countStep("after_wrap");

        clearPulse("async_clear");
        countStep("clear_resume");
        countStep("clear_resume2");

        for (int i = 0; i < 3; i++)
            applyStimulus("pause", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2,
                          4'(cur / 10), 4'(cur % 10));
        countStep("pause_resume");

        // Clear outranks load, including across a rising edge.
        PE0 = 1'b0; PE1 = 1'b0; D0 = 4'd4; D1 = 4'd2;
        CR0 = 1'b0; CR1 = 1'b0;
        #10;
        checkOutput("clr_over_load", {Q1, Q0}, 8'h00);
        @(posedge CP);
        @(negedge CP);
        checkOutput("clr_over_load_edge", {Q1, Q0}, 8'h00);
        CR0 = 1'b1; CR1 = 1'b1;
        cur = 0;
        countStep("clr_release");

        applyStimulus("load_no_cep", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd2, 4'd2, 4'd4);

        applyStimulus("load_oor", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 4'd0, 4'd0, 4'd12);
        for (int u = 11; u >= 0; u--)
            applyStimulus("oor_count", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 4'd2,
                          4'd0, 4'(u));
        cur = 0;
        countStep("oor_wrap");

        // Units reload at 20 while tens still borrows using the pre-edge TC0.
        while (cur != 20) countStep("to_twenty");
        applyStimulus("load_units_tens_count", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                      4'd7, 4'd2, 4'd1, 4'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
